// File: rtl/core_rvfi_pkg.sv
// Shared definitions for the RVFI retirement checker and trace tooling:
// violation cause codes, checker FSM states and the memory-mask helper.
package core_rvfi_pkg;

   typedef enum logic [3:0] {
      CAUSE_NONE         = 4'd0,
      CAUSE_RS1_MISMATCH = 4'd1,
      CAUSE_RS2_MISMATCH = 4'd2,
      CAUSE_X0_WRITE     = 4'd3,
      CAUSE_PC_DISCONT   = 4'd4,
      CAUSE_PC_MISALIGN  = 4'd5,
      CAUSE_MEM_BOTH     = 4'd6,
      CAUSE_MEM_MASK     = 4'd7
   } cause_e;

   typedef enum logic [1:0] {
      ST_WAIT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_e;

   // A zero mask is no access; otherwise the mask must be a naturally aligned
   // 1/2/4/8-byte lane group and the address offset aligned to that size.
   function automatic logic mem_access_ok(input logic [7:0] mask, input logic [2:0] addr_lo);
      logic [3:0] size;
      logic [2:0] low;
      if (mask == 8'h00) return 1'b1;
      case (mask)
         8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80: size = 4'd1;
         8'h03, 8'h0c, 8'h30, 8'hc0:                             size = 4'd2;
         8'h0f, 8'hf0:                                           size = 4'd4;
         8'hff:                                                  size = 4'd8;
         default:                                                size = 4'd0;
      endcase
      low = 3'(size - 4'd1);
      return (size != 4'd0) && ((addr_lo & low) == 3'd0);
   endfunction

endpackage

// File: rtl/core_rvfi_checker_regs.sv
// Shadow architectural register file: 32 x XLEN values with a known bit each.
// x0 always reads as known zero; writes commit on the retiring edge.
module core_rvfi_checker_regs #(
   parameter int XLEN = 64
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [4:0]      rs1_addr_i,
   output logic [XLEN-1:0] rs1_data_o,
   output logic            rs1_known_o,
   input  logic [4:0]      rs2_addr_i,
   output logic [XLEN-1:0] rs2_data_o,
   output logic            rs2_known_o,
   input  logic            we_i,
   input  logic [4:0]      wr_addr_i,
   input  logic [XLEN-1:0] wr_data_i
);

   logic [XLEN-1:0] data_q [32];
   logic [31:0]     known_q;
   logic            wr_ok;

   assign wr_ok = we_i && (wr_addr_i != 5'd0);

   // NOTE: non-blocking assignments in clocked blocks so every register
   // samples pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         known_q <= '0;
      end else if (wr_ok) begin
         known_q[wr_addr_i] <= 1'b1;
      end
   end

   // NOTE: the value array is deliberately not reset; the known bits gate
   // every use, so clearing them is enough and keeps this a plain RAM.
   always_ff @(posedge clk_i) begin
      if (wr_ok) begin
         data_q[wr_addr_i] <= wr_data_i;
      end
   end

   // A write from retirement N lands on the edge that retires it, so the
   // combinational read for retirement N+1 already sees the new value.
   assign rs1_known_o = (rs1_addr_i == 5'd0) || known_q[rs1_addr_i];
   assign rs2_known_o = (rs2_addr_i == 5'd0) || known_q[rs2_addr_i];
   assign rs1_data_o  = (rs1_addr_i == 5'd0) ? '0 : data_q[rs1_addr_i];
   assign rs2_data_o  = (rs2_addr_i == 5'd0) ? '0 : data_q[rs2_addr_i];

endmodule

// File: rtl/core_rvfi_checker.sv
// RVFI retirement checker: shadow regfile + expected-PC tracking, latching the
// first violation. Define RVFI_CHECKER_MEM_EN to enable memory-mask checks (6, 7).
module core_rvfi_checker
   import core_rvfi_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int ILEN = 32,
   parameter int NRET = 1
) (
   input  logic              g_clk,
   input  logic              g_reset,
   input  logic              rvfi_valid,
   input  logic [ILEN-1:0]   rvfi_insn,
   input  logic              rvfi_intr,
   input  logic              rvfi_trap,
   input  logic [4:0]        rvfi_rs1_addr,
   input  logic [4:0]        rvfi_rs2_addr,
   input  logic [XLEN-1:0]   rvfi_rs1_rdata,
   input  logic [XLEN-1:0]   rvfi_rs2_rdata,
   input  logic [4:0]        rvfi_rd_addr,
   input  logic [XLEN-1:0]   rvfi_rd_wdata,
   input  logic [XLEN-1:0]   rvfi_pc_rdata,
   input  logic [XLEN-1:0]   rvfi_pc_wdata,
   input  logic [XLEN-1:0]   rvfi_mem_addr,
   input  logic [XLEN/8-1:0] rvfi_mem_rmask,
   input  logic [XLEN/8-1:0] rvfi_mem_wmask,
   output logic              chk_error,
   output logic [3:0]        chk_cause,
   output logic [XLEN-1:0]   chk_err_pc,
   output logic [63:0]       chk_err_order,
   output logic [63:0]       chk_retired
);

   state_e          state_q, state_d;
   logic            error_q, error_d;
   logic [3:0]      cause_q, cause_d;
   logic [XLEN-1:0] err_pc_q, err_pc_d;
   logic [63:0]     err_order_q, err_order_d;
   logic [63:0]     retired_q, retired_d;
   logic [XLEN-1:0] exp_pc_q, exp_pc_d;

   logic [XLEN-1:0] rs1_data, rs2_data;
   logic            rs1_known, rs2_known;
   logic            wr_en, fire, mem_both, mem_bad, unused_ok;
   cause_e          cause_now;

   core_rvfi_checker_regs #(.XLEN(XLEN)) u_regs (
      .clk_i       (g_clk),
      .rst_i       (g_reset),
      .rs1_addr_i  (rvfi_rs1_addr),
      .rs1_data_o  (rs1_data),
      .rs1_known_o (rs1_known),
      .rs2_addr_i  (rvfi_rs2_addr),
      .rs2_data_o  (rs2_data),
      .rs2_known_o (rs2_known),
      .we_i        (wr_en),
      .wr_addr_i   (rvfi_rd_addr),
      .wr_data_i   (rvfi_rd_wdata)
   );

`ifdef RVFI_CHECKER_MEM_EN
   assign mem_both  = (|rvfi_mem_rmask) && (|rvfi_mem_wmask);
   assign mem_bad   = !mem_access_ok(8'(rvfi_mem_rmask | rvfi_mem_wmask), rvfi_mem_addr[2:0]);
   assign unused_ok = ^{rvfi_insn, rvfi_mem_addr[XLEN-1:3], NRET != 1};
`else
   assign mem_both  = 1'b0;
   assign mem_bad   = 1'b0;
   assign unused_ok = ^{rvfi_insn, rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask, NRET != 1};
`endif

   assign fire = rvfi_valid && (state_q != ST_HALT);

   // Priority chain: the lowest-numbered failing check wins.
   always_comb begin
      cause_now = CAUSE_NONE;
      if (rs1_known && (rvfi_rs1_rdata != rs1_data))
         cause_now = CAUSE_RS1_MISMATCH;
      else if (rs2_known && (rvfi_rs2_rdata != rs2_data))
         cause_now = CAUSE_RS2_MISMATCH;
      else if ((rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != '0))
         cause_now = CAUSE_X0_WRITE;
      else if ((state_q == ST_RUN) && (rvfi_pc_rdata != exp_pc_q) && !rvfi_intr)
         cause_now = CAUSE_PC_DISCONT;
      else if (rvfi_pc_wdata[0] && !rvfi_trap)
         cause_now = CAUSE_PC_MISALIGN;
      else if (mem_both)
         cause_now = CAUSE_MEM_BOTH;
      else if (mem_bad)
         cause_now = CAUSE_MEM_MASK;
   end

   // NOTE: every signal driven here gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      error_d     = error_q;
      cause_d     = cause_q;
      err_pc_d    = err_pc_q;
      err_order_d = err_order_q;
      retired_d   = retired_q;
      exp_pc_d    = exp_pc_q;
      wr_en       = 1'b0;
      if (fire) begin
         if (cause_now != CAUSE_NONE) begin
            state_d     = ST_HALT;
            error_d     = 1'b1;
            cause_d     = cause_now;
            err_pc_d    = rvfi_pc_rdata;
            err_order_d = retired_q;
         end else begin
            state_d   = ST_RUN;
            wr_en     = (rvfi_rd_addr != 5'd0);
            exp_pc_d  = rvfi_pc_wdata;
            retired_d = retired_q + 64'd1;
         end
      end
   end

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         state_q     <= ST_WAIT;
         error_q     <= 1'b0;
         cause_q     <= 4'd0;
         err_pc_q    <= '0;
         err_order_q <= '0;
         retired_q   <= '0;
         exp_pc_q    <= '0;
      end else begin
         state_q     <= state_d;
         error_q     <= error_d;
         cause_q     <= cause_d;
         err_pc_q    <= err_pc_d;
         err_order_q <= err_order_d;
         retired_q   <= retired_d;
         exp_pc_q    <= exp_pc_d;
      end
   end

   assign chk_error     = error_q;
   assign chk_cause     = cause_q;
   assign chk_err_pc    = err_pc_q;
   assign chk_err_order = err_order_q;
   assign chk_retired   = retired_q;

endmodule

// File: tb/tb_core_rvfi_checker.sv
// Self-checking bench for core_rvfi_checker: directed vector table, hand
// sequences for halt/reset corners, and random streams against a model.
module tb_core_rvfi_checker;

   localparam int XLEN = 64;
   localparam logic [63:0] P0 = 64'h8000_0000;
`ifdef RVFI_CHECKER_MEM_EN
   localparam bit MEM = 1'b1;
`else
   localparam bit MEM = 1'b0;
`endif

   logic        g_clk = 1'b0;
   logic        g_reset;
   logic        rvfi_valid, rvfi_intr, rvfi_trap;
   logic [31:0] rvfi_insn;
   logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
   logic [63:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
   logic [63:0] rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr;
   logic [7:0]  rvfi_mem_rmask, rvfi_mem_wmask;
   logic        chk_error;
   logic [3:0]  chk_cause;
   logic [63:0] chk_err_pc, chk_err_order, chk_retired;

   always #5 g_clk = ~g_clk;

   core_rvfi_checker #(.XLEN(XLEN), .ILEN(32), .NRET(1)) dut (
      .g_clk          (g_clk),
      .g_reset        (g_reset),
      .rvfi_valid     (rvfi_valid),
      .rvfi_insn      (rvfi_insn),
      .rvfi_intr      (rvfi_intr),
      .rvfi_trap      (rvfi_trap),
      .rvfi_rs1_addr  (rvfi_rs1_addr),
      .rvfi_rs2_addr  (rvfi_rs2_addr),
      .rvfi_rs1_rdata (rvfi_rs1_rdata),
      .rvfi_rs2_rdata (rvfi_rs2_rdata),
      .rvfi_rd_addr   (rvfi_rd_addr),
      .rvfi_rd_wdata  (rvfi_rd_wdata),
      .rvfi_pc_rdata  (rvfi_pc_rdata),
      .rvfi_pc_wdata  (rvfi_pc_wdata),
      .rvfi_mem_addr  (rvfi_mem_addr),
      .rvfi_mem_rmask (rvfi_mem_rmask),
      .rvfi_mem_wmask (rvfi_mem_wmask),
      .chk_error      (chk_error),
      .chk_cause      (chk_cause),
      .chk_err_pc     (chk_err_pc),
      .chk_err_order  (chk_err_order),
      .chk_retired    (chk_retired)
   );

   typedef struct {
      bit          rst;
      logic [63:0] pc, npc;
      logic [4:0]  rs1;
      logic [63:0] v1;
      logic [4:0]  rs2;
      logic [63:0] v2;
      logic [4:0]  rd;
      logic [63:0] wd;
      bit          intr, trap;
      logic [7:0]  rm, wm;
      logic [63:0] addr;
      bit          e_err;
      logic [3:0]  e_cause;
      logic [63:0] e_ret;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state, expressed directly in terms of the rules.
   logic [63:0] m_reg [32];
   bit          m_kn [32];
   logic [63:0] m_pc, m_epc, m_order, m_ret;
   bit          m_started, m_halted, m_err;
   logic [3:0]  m_cause;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(bit rst, logic [63:0] pc, logic [63:0] npc,
                               logic [4:0] rs1, logic [63:0] v1, logic [4:0] rs2, logic [63:0] v2,
                               logic [4:0] rd, logic [63:0] wd, bit intr, bit trap,
                               logic [7:0] rm, logic [7:0] wm, logic [63:0] addr,
                               bit e_err, logic [3:0] e_cause, logic [63:0] e_ret);
      vec_t v;
      v.rst = rst; v.pc = pc; v.npc = npc; v.rs1 = rs1; v.v1 = v1; v.rs2 = rs2; v.v2 = v2;
      v.rd = rd; v.wd = wd; v.intr = intr; v.trap = trap; v.rm = rm; v.wm = wm; v.addr = addr;
      v.e_err = e_err; v.e_cause = e_cause; v.e_ret = e_ret;
      return v;
   endfunction

   function automatic bit mem_bad(logic [7:0] m, logic [63:0] a);
      int n, lo;
      n = $countones(m);
      if (n == 0) return 1'b0;
      lo = 0;
      while (m[lo] == 1'b0) lo++;
      if (!(n inside {1, 2, 4, 8})) return 1'b1;
      if (m != 8'((2 ** n - 1) << lo)) return 1'b1;
      if ((lo % n) != 0) return 1'b1;
      if ((int'(a[2:0]) % n) != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_reg[i] = '0;
         m_kn[i]  = (i == 0);
      end
      m_pc = '0; m_epc = '0; m_order = '0; m_ret = '0;
      m_started = 0; m_halted = 0; m_err = 0; m_cause = '0;
   endtask

   task automatic model_step();
      logic [3:0] c;
      if (m_halted || !rvfi_valid) return;
      c = 4'd0;
      if (c == 0 && m_kn[rvfi_rs1_addr] && m_reg[rvfi_rs1_addr] != rvfi_rs1_rdata) c = 4'd1;
      if (c == 0 && m_kn[rvfi_rs2_addr] && m_reg[rvfi_rs2_addr] != rvfi_rs2_rdata) c = 4'd2;
      if (c == 0 && rvfi_rd_addr == 0 && rvfi_rd_wdata != 0) c = 4'd3;
      if (c == 0 && m_started && rvfi_pc_rdata != m_pc && !rvfi_intr) c = 4'd4;
      if (c == 0 && rvfi_pc_wdata[0] && !rvfi_trap) c = 4'd5;
`ifdef RVFI_CHECKER_MEM_EN
      if (c == 0 && rvfi_mem_rmask != 0 && rvfi_mem_wmask != 0) c = 4'd6;
      if (c == 0 && mem_bad(rvfi_mem_rmask | rvfi_mem_wmask, rvfi_mem_addr)) c = 4'd7;
`endif
      if (c != 0) begin
         m_halted = 1; m_err = 1; m_cause = c; m_epc = rvfi_pc_rdata; m_order = m_ret;
      end else begin
         m_started = 1;
         if (rvfi_rd_addr != 0) begin
            m_reg[rvfi_rd_addr] = rvfi_rd_wdata;
            m_kn[rvfi_rd_addr]  = 1;
         end
         m_pc  = rvfi_pc_wdata;
         m_ret = m_ret + 1;
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, " error"}, 64'(chk_error), 64'(m_err));
      check({tag, " cause"}, 64'(chk_cause), 64'(m_cause));
      check({tag, " err_pc"}, chk_err_pc, m_epc);
      check({tag, " err_order"}, chk_err_order, m_order);
      check({tag, " retired"}, chk_retired, m_ret);
   endtask

   task automatic do_reset();
      @(negedge g_clk);
      g_reset    = 1'b1;
      rvfi_valid = 1'b0;
      model_reset();
      @(negedge g_clk);
      g_reset = 1'b0;
   endtask

   // Drive one retirement at the falling edge; it is sampled on the next rising edge.
   task automatic apply(input vec_t v);
      @(negedge g_clk);
      rvfi_valid = 1'b1;
      rvfi_pc_rdata = v.pc;  rvfi_pc_wdata = v.npc;
      rvfi_rs1_addr = v.rs1; rvfi_rs1_rdata = v.v1;
      rvfi_rs2_addr = v.rs2; rvfi_rs2_rdata = v.v2;
      rvfi_rd_addr = v.rd;   rvfi_rd_wdata = v.wd;
      rvfi_intr = v.intr;    rvfi_trap = v.trap;
      rvfi_mem_rmask = v.rm; rvfi_mem_wmask = v.wm; rvfi_mem_addr = v.addr;
      @(posedge g_clk);
      model_step();
      #1;
   endtask

   task automatic gen_random();
      logic [7:0] good [8] = '{8'h01, 8'h02, 8'h0c, 8'h30, 8'h0f, 8'hf0, 8'hff, 8'h80};
      int sel;
      rvfi_valid = ($urandom_range(9) < 8);
      rvfi_rs1_addr = 5'($urandom_range(31));
      rvfi_rs1_rdata = (m_kn[rvfi_rs1_addr] && $urandom_range(49) != 0) ? m_reg[rvfi_rs1_addr] : {$urandom, $urandom};
      rvfi_rs2_addr = 5'($urandom_range(31));
      rvfi_rs2_rdata = (m_kn[rvfi_rs2_addr] && $urandom_range(49) != 0) ? m_reg[rvfi_rs2_addr] : {$urandom, $urandom};
      rvfi_rd_addr = 5'($urandom_range(31));
      rvfi_rd_wdata = (rvfi_rd_addr == 0 && $urandom_range(29) != 0) ? 64'd0 : {$urandom, $urandom};
      rvfi_pc_rdata = (m_started && $urandom_range(19) != 0) ? m_pc : ({$urandom, $urandom} & ~64'h1);
      rvfi_intr = ($urandom_range(9) == 0);
      rvfi_trap = ($urandom_range(19) == 0);
      rvfi_pc_wdata = ($urandom_range(39) == 0) ? rvfi_pc_rdata + 64'd5 : rvfi_pc_rdata + 64'd4;
      rvfi_mem_addr = {$urandom, $urandom};
      if ($urandom_range(1) == 0) rvfi_mem_addr[2:0] = 3'd0;
      rvfi_mem_rmask = 8'h00;
      rvfi_mem_wmask = 8'h00;
      sel = $urandom_range(9);
      if (sel == 6) rvfi_mem_rmask = good[$urandom_range(7)];
      if (sel == 7) rvfi_mem_wmask = good[$urandom_range(7)];
      if (sel == 8) rvfi_mem_rmask = 8'($urandom);
      if (sel == 9) begin
         rvfi_mem_rmask = 8'($urandom);
         rvfi_mem_wmask = 8'($urandom);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      vec_t vecs[$];

      g_reset = 1'b1; rvfi_valid = 1'b0; rvfi_insn = 32'h0000_0013;
      rvfi_intr = 0; rvfi_trap = 0; rvfi_rs1_addr = 0; rvfi_rs2_addr = 0; rvfi_rd_addr = 0;
      rvfi_rs1_rdata = 0; rvfi_rs2_rdata = 0; rvfi_rd_wdata = 0;
      rvfi_pc_rdata = 0; rvfi_pc_wdata = 0; rvfi_mem_addr = 0; rvfi_mem_rmask = 0; rvfi_mem_wmask = 0;
      model_reset();

      //          rst pc       npc        rs1 v1     rs2 v2      rd wd     in tr rm     wm     addr        err  cause ret
      vecs.push_back(mk(1, P0,       P0+4,      0, 0,      0, 0,       5, 'h10,  0, 0, 8'h00, 8'h00, 0,          0,   0,    1));
      vecs.push_back(mk(0, P0+4,     P0+8,      5, 'h10,   0, 0,       6, 'h20,  0, 0, 8'h00, 8'h00, 0,          0,   0,    2));
      vecs.push_back(mk(1, P0,       P0+8,      0, 0,      0, 0,       0, 0,     0, 0, 8'h00, 8'h00, 0,          0,   0,    1));
      vecs.push_back(mk(0, P0+'h10,  P0+'h14,   0, 0,      0, 0,       0, 0,     0, 0, 8'h00, 8'h00, 0,          1,   4,    1));
      vecs.push_back(mk(1, P0,       P0+8,      0, 0,      0, 0,       0, 0,     0, 0, 8'h00, 8'h00, 0,          0,   0,    1));
      vecs.push_back(mk(0, P0+'h10,  P0+'h14,   0, 0,      0, 0,       0, 0,     1, 0, 8'h00, 8'h00, 0,          0,   0,    2));
      vecs.push_back(mk(1, P0,       P0+4,      0, 0,      0, 0,       0, 5,     0, 0, 8'h00, 8'h00, 0,          1,   3,    0));
      vecs.push_back(mk(1, P0,       P0+4,      0, 0,      0, 0,       0, 0,     0, 0, 8'h00, 8'h00, 0,          0,   0,    1));
      vecs.push_back(mk(1, P0,       P0+5,      0, 0,      0, 0,       0, 0,     0, 0, 8'h00, 8'h00, 0,          1,   5,    0));
      vecs.push_back(mk(1, P0,       P0+5,      0, 0,      0, 0,       0, 0,     0, 1, 8'h00, 8'h00, 0,          0,   0,    1));
      vecs.push_back(mk(1, P0,       P0+4,      0, 1,      0, 0,       0, 5,     0, 0, 8'h00, 8'h00, 0,          1,   1,    0));
      vecs.push_back(mk(1, P0,       P0+4,      0, 0,      0, 0,       7, 'hAA,  0, 0, 8'h00, 8'h00, 0,          0,   0,    1));
      vecs.push_back(mk(0, P0+4,     P0+8,      0, 0,      7, 'hAB,    0, 0,     0, 0, 8'h00, 8'h00, 0,          1,   2,    1));
      vecs.push_back(mk(1, P0,       P0+4,      0, 0,      0, 0,       0, 0,     0, 0, 8'h01, 8'h01, 'h1000,     MEM, MEM ? 4'd6 : 4'd0, MEM ? 0 : 1));
      vecs.push_back(mk(1, P0,       P0+4,      0, 0,      0, 0,       0, 0,     0, 0, 8'h05, 8'h00, 'h1000,     MEM, MEM ? 4'd7 : 4'd0, MEM ? 0 : 1));
      vecs.push_back(mk(1, P0,       P0+4,      0, 0,      0, 0,       0, 0,     0, 0, 8'h0F, 8'h00, 'h1004,     0,   0,    1));
      vecs.push_back(mk(1, P0,       P0+4,      0, 0,      0, 0,       0, 0,     0, 0, 8'h00, 8'h0C, 'h1002,     0,   0,    1));
      vecs.push_back(mk(1, P0,       P0+4,      0, 0,      0, 0,       0, 0,     0, 0, 8'h0F, 8'h00, 'h1002,     MEM, MEM ? 4'd7 : 4'd0, MEM ? 0 : 1));
      vecs.push_back(mk(1, P0,       P0+4,      0, 0,      0, 0,       0, 0,     0, 0, 8'h06, 8'h00, 'h1001,     MEM, MEM ? 4'd7 : 4'd0, MEM ? 0 : 1));
      vecs.push_back(mk(1, P0,       P0+4,      0, 0,      0, 0,       9, 1,     0, 0, 8'h00, 8'h00, 0,          0,   0,    1));
      vecs.push_back(mk(0, P0+4,     P0+8,      9, 1,      0, 0,       9, 2,     0, 0, 8'h00, 8'h00, 0,          0,   0,    2));
      vecs.push_back(mk(0, P0+8,     P0+'hC,    9, 2,      9, 2,       0, 0,     0, 0, 8'h00, 8'h00, 0,          0,   0,    3));

      // Reset state.
      do_reset();
      check("reset error", 64'(chk_error), 64'd0);
      check("reset cause", 64'(chk_cause), 64'd0);
      check("reset err_pc", chk_err_pc, 64'd0);
      check("reset err_order", chk_err_order, 64'd0);
      check("reset retired", chk_retired, 64'd0);

      foreach (vecs[i]) begin
         if (vecs[i].rst) do_reset();
         apply(vecs[i]);
         check($sformatf("vec%0d error", i), 64'(chk_error), 64'(vecs[i].e_err));
         check($sformatf("vec%0d cause", i), 64'(chk_cause), 64'(vecs[i].e_cause));
         check($sformatf("vec%0d retired", i), chk_retired, vecs[i].e_ret);
      end

      // First violation is latched with PC and order, then HALT ignores traffic.
      do_reset();
      apply(mk(0, P0, P0+4, 0, 0, 0, 0, 5, 'h10, 0, 0, 0, 0, 0, 0, 0, 0));
      apply(mk(0, P0+4, P0+8, 5, 'h11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      check("halt error", 64'(chk_error), 64'd1);
      check("halt cause", 64'(chk_cause), 64'd1);
      check("halt err_pc", chk_err_pc, P0+4);
      check("halt err_order", chk_err_order, 64'd1);
      check("halt retired", chk_retired, 64'd1);
      apply(mk(0, P0+'h40, P0+'h43, 0, 7, 0, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0));
      apply(mk(0, P0+8, P0+'hC, 0, 0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0));
      check_model("after halt");
      check("after halt err_pc", chk_err_pc, P0+4);

      // Mid-stream asynchronous reset, then restart at an unrelated PC.
      do_reset();
      apply(mk(0, P0,   P0+4,  0, 0, 0, 0, 5, 'h10, 0, 0, 0, 0, 0, 0, 0, 0));
      apply(mk(0, P0+4, P0+8,  5, 'h10, 0, 0, 6, 'h20, 0, 0, 0, 0, 0, 0, 0, 0));
      apply(mk(0, P0+8, P0+'hC, 6, 'h20, 0, 0, 7, 'h30, 0, 0, 0, 0, 0, 0, 0, 0));
      check("pre-reset retired", chk_retired, 64'd3);
      @(negedge g_clk);
      rvfi_valid = 1'b0;
      g_reset = 1'b1;
      #1;
      model_reset();
      check_model("async reset");
      @(negedge g_clk);
      g_reset = 1'b0;
      apply(mk(0, P0+'h100, P0+'h104, 5, 'hDEAD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      check("post-reset error", 64'(chk_error), 64'd0);
      check("post-reset retired", chk_retired, 64'd1);

      // Random back-to-back streams against the reference model.
      for (int ep = 0; ep < 30; ep++) begin
         do_reset();
         for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge g_clk);
            gen_random();
            @(posedge g_clk);
            model_step();
            #1;
            check_model($sformatf("rand ep%0d cyc%0d", ep, cyc));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
